// File: rtl/cram_palette_writer_if.sv
// Host-side request/clear signals and color RAM bus signals of the palette writer.
interface cram_palette_writer_if;
   logic       REQ_VALID;
   logic       REQ_READY;
   logic [4:0] REQ_INDEX;
   logic [8:0] REQ_COLOR;
   logic       CLEAR_START;
   logic [8:0] CLEAR_COLOR;
   logic       BUSRQ;
   logic       BUSGNT;
   logic       BUS_OE;
   logic       CRAMn;
   logic [7:0] BD;
   logic [5:0] BA;
   logic       BUSY;
   logic       DONE;

   modport master (
      output REQ_VALID, REQ_INDEX, REQ_COLOR, CLEAR_START, CLEAR_COLOR, BUSGNT,
      input  REQ_READY, BUSRQ, BUS_OE, CRAMn, BD, BA, BUSY, DONE
   );

   modport slave (
      input  REQ_VALID, REQ_INDEX, REQ_COLOR, CLEAR_START, CLEAR_COLOR, BUSGNT,
      output REQ_READY, BUSRQ, BUS_OE, CRAMn, BD, BA, BUSY, DONE
   );
endinterface

// File: rtl/cram_palette_writer.sv
// Queues palette writes (or a clear sweep) and plays them out as CRAMn/BA/BD cycles; all outputs registered.
// Per entry: load, SETUP until CLK5n phase, 2-cycle strobe, 1 hold; REQ_READY drops when full or clearing.
module cram_palette_writer #(
   parameter int FIFO_DEPTH    = 4,
   parameter int CLEAR_ENTRIES = 32
) (
   input  logic                 CLK10,
   input  logic                 RESET,
   input  logic                 CLK5n,
   cram_palette_writer_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, WAIT_GNT, SETUP, STROBE, HOLD} state_t;

   state_t      state_q;
   logic [13:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0] count_q, count_d;
   logic        clearing_q, clearing_d, clr_done_q;
   logic [4:0]  clr_cnt_q;
   logic [8:0]  clr_col_q;
   logic        strb_q;
   logic        req_ready_q, busrq_q, bus_oe_q, cramn_q, busy_q, done_q;
   logic [7:0]  bd_q;
   logic [5:0]  ba_q;

   logic        push, pop, clr_go, clr_last, more_work, to_idle, idle_next;
   logic [13:0] head;
   logic [4:0]  src_idx;
   logic [8:0]  src_col;

   assign push      = bus.REQ_VALID && req_ready_q;
   assign pop       = (state_q == STROBE) && strb_q && !clearing_q;
   assign clr_go    = bus.CLEAR_START && (state_q == IDLE) && (count_q == '0);
   assign clr_last  = (clr_cnt_q == 5'(CLEAR_ENTRIES - 1));
   // During a clear the FIFO is held empty, so only the sweep counter decides.
   assign more_work = clearing_q ? !clr_done_q : (count_q != '0);
   assign to_idle   = (state_q == HOLD) && !more_work;
   assign idle_next = ((state_q == IDLE) && !clr_go && (count_q == '0)) || to_idle;
   assign count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);
   assign clearing_d = clr_go ? 1'b1 : (to_idle ? 1'b0 : clearing_q);

   assign head    = mem_q[rd_ptr_q];
   assign src_idx = clearing_q ? clr_cnt_q : head[13:9];
   assign src_col = clearing_q ? clr_col_q : head[8:0];

   always_ff @(posedge CLK10) begin
      if (RESET) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         clearing_q  <= 1'b0;
         clr_done_q  <= 1'b0;
         clr_cnt_q   <= '0;
         clr_col_q   <= '0;
         strb_q      <= 1'b0;
         req_ready_q <= 1'b1;
         busrq_q     <= 1'b0;
         bus_oe_q    <= 1'b0;
         cramn_q     <= 1'b1;
         bd_q        <= '0;
         ba_q        <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q      <= 1'b0;
         count_q     <= count_d;
         clearing_q  <= clearing_d;
         busy_q      <= !idle_next || (count_d != '0);
         req_ready_q <= (count_d != (AW+1)'(FIFO_DEPTH)) && !clearing_d;
         if (push) begin
            mem_q[wr_ptr_q] <= {bus.REQ_INDEX, bus.REQ_COLOR};
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);

         case (state_q)
            IDLE: begin
               if (clr_go) begin
                  clr_cnt_q  <= '0;
                  clr_col_q  <= bus.CLEAR_COLOR;
                  clr_done_q <= 1'b0;
               end
               if (clr_go || (count_q != '0)) begin
                  busrq_q <= 1'b1;
                  state_q <= WAIT_GNT;
               end
            end
            WAIT_GNT: begin
               if (bus.BUSGNT) begin
                  bus_oe_q <= 1'b1;
                  ba_q     <= {src_col[8], src_idx};
                  bd_q     <= src_col[7:0];
                  cramn_q  <= 1'b1;
                  state_q  <= SETUP;
               end
            end
            SETUP: begin
               if (!bus.BUSGNT) begin
                  bus_oe_q <= 1'b0;
                  state_q  <= WAIT_GNT;
               end else if (CLK5n) begin
                  // CLK5n falls at this same edge, so WE spans only the first strobe cycle.
                  cramn_q <= 1'b0;
                  strb_q  <= 1'b0;
                  state_q <= STROBE;
               end
            end
            STROBE: begin
               if (!strb_q) begin
                  strb_q <= 1'b1;
               end else begin
                  cramn_q <= 1'b1;
                  if (clearing_q) begin
                     if (clr_last) clr_done_q <= 1'b1;
                     else          clr_cnt_q  <= clr_cnt_q + 5'd1;
                  end
                  state_q <= HOLD;
               end
            end
            HOLD: begin
               if (!more_work) begin
                  busrq_q  <= 1'b0;
                  bus_oe_q <= 1'b0;
                  ba_q     <= '0;
                  bd_q     <= '0;
                  done_q   <= 1'b1;
                  state_q  <= IDLE;
               end else if (bus.BUSGNT) begin
                  ba_q    <= {src_col[8], src_idx};
                  bd_q    <= src_col[7:0];
                  state_q <= SETUP;
               end else begin
                  bus_oe_q <= 1'b0;
                  state_q  <= WAIT_GNT;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.REQ_READY = req_ready_q;
   assign bus.BUSRQ     = busrq_q;
   assign bus.BUS_OE    = bus_oe_q;
   assign bus.CRAMn     = cramn_q;
   assign bus.BD        = bd_q;
   assign bus.BA        = ba_q;
   assign bus.BUSY      = busy_q;
   assign bus.DONE      = done_q;
endmodule

// File: tb/tb_cram_palette_writer.sv
// Directed and randomized checks of cram_palette_writer against a queue of expected RAM writes.
module tb_cram_palette_writer;
   logic CLK10 = 1'b0;
   logic CLK5n = 1'b1;
   logic RESET;

   cram_palette_writer_if bif();

   cram_palette_writer #(.FIFO_DEPTH(4), .CLEAR_ENTRIES(32)) dut (
      .CLK10 (CLK10),
      .RESET (RESET),
      .CLK5n (CLK5n),
      .bus   (bif.slave)
   );

   always #5 CLK10 = ~CLK10;
   always @(posedge CLK10) CLK5n <= ~CLK5n;

   int checks = 0;
   int failures = 0;
   logic [13:0] exp_q[$];   // expected RAM writes as {index, color}
   int writes_cnt = 0, done_cnt = 0, busrq_fall = 0, werun = 0, lowrun = 0;
   logic busrq_prev = 1'b0;
   logic [5:0] last_ba;
   logic [7:0] last_bd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // RAM-side observer: a write is any cycle with ~CRAMn & ~CLK5n.
   always @(negedge CLK10) begin
      logic [13:0] e;
      #1;
      if (RESET) begin
         werun  = 0;
         lowrun = 0;
      end
      if (!bif.CRAMn && !CLK5n) begin
         writes_cnt++;
         werun++;
         last_ba = bif.BA;
         last_bd = bif.BD;
         chk("wr_expected", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("wr_ba", 32'(bif.BA), 32'({e[8], e[13:9]}));
            chk("wr_bd", 32'(bif.BD), 32'(e[7:0]));
         end
      end else if (werun != 0) begin
         chk("we_width", werun, 1);
         werun = 0;
      end
      if (!bif.CRAMn) begin
         lowrun++;
         chk("oe_in_strobe", 32'(bif.BUS_OE), 1);
      end else if (lowrun != 0) begin
         chk("cramn_low_width", lowrun, 2);
         lowrun = 0;
      end
      if (bif.DONE) done_cnt++;
      if (busrq_prev && !bif.BUSRQ) busrq_fall++;
      busrq_prev = bif.BUSRQ;
   end

   task automatic push(input logic [4:0] i, input logic [8:0] c);
      int n;
      n = 0;
      @(negedge CLK10);
      bif.REQ_VALID = 1'b1;
      bif.REQ_INDEX = i;
      bif.REQ_COLOR = c;
      while (!bif.REQ_READY && n < 200) begin
         @(negedge CLK10);
         n++;
      end
      chk("push_ready", 32'(n < 200), 1);
      if (n < 200) exp_q.push_back({i, c});
      @(negedge CLK10);
      bif.REQ_VALID = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (!bif.DONE && n < budget) begin
         @(negedge CLK10);
         n++;
      end
      chk({tag, "_seen"}, 32'(n < budget), 1);
      if (n < budget) begin
         chk({tag, "_busrq"}, 32'(bif.BUSRQ), 0);
         chk({tag, "_oe"}, 32'(bif.BUS_OE), 0);
         chk({tag, "_ba"}, 32'(bif.BA), 0);
         chk({tag, "_bd"}, 32'(bif.BD), 0);
         @(negedge CLK10);
         chk({tag, "_pulse"}, 32'(bif.DONE), 0);
      end
   endtask

   initial begin
      int n, w0, d0, f0, bad, rdy_hi;
      logic [31:0] r;
      logic [8:0] t3c [4];
      t3c = '{9'h000, 9'h1FF, 9'h0F0, 9'h10F};

      RESET = 1'b1;
      bif.REQ_VALID = 1'b0;
      bif.REQ_INDEX = '0;
      bif.REQ_COLOR = '0;
      bif.CLEAR_START = 1'b0;
      bif.CLEAR_COLOR = '0;
      bif.BUSGNT = 1'b0;
      repeat (3) @(negedge CLK10);
      chk("rst_busrq", 32'(bif.BUSRQ), 0);
      chk("rst_oe", 32'(bif.BUS_OE), 0);
      chk("rst_cramn", 32'(bif.CRAMn), 1);
      chk("rst_bd", 32'(bif.BD), 0);
      chk("rst_ba", 32'(bif.BA), 0);
      chk("rst_done", 32'(bif.DONE), 0);
      chk("rst_busy", 32'(bif.BUSY), 0);
      chk("rst_ready", 32'(bif.REQ_READY), 1);
      RESET = 1'b0;

      // Single write with grant tied high
      bif.BUSGNT = 1'b1;
      w0 = writes_cnt;
      push(5'd5, 9'h1A3);
      wait_done("t1_done", 100);
      chk("t1_writes", writes_cnt - w0, 1);
      chk("t1_ba", 32'(last_ba), 32'h25);
      chk("t1_bd", 32'(last_bd), 32'hA3);
      chk("t1_busy", 32'(bif.BUSY), 0);

      // Grant arrives late
      bif.BUSGNT = 1'b0;
      r = $urandom;
      w0 = writes_cnt;
      push(r[4:0], r[13:5]);
      n = 0;
      while (!bif.BUSRQ && n < 50) begin @(negedge CLK10); n++; end
      chk("t2_busrq", 32'(n < 50), 1);
      bad = 0;
      repeat (7) begin
         @(negedge CLK10);
         if (!bif.CRAMn || bif.BUS_OE) bad++;
      end
      chk("t2_idle_before_gnt", bad, 0);
      bif.BUSGNT = 1'b1;
      wait_done("t2_done", 100);
      chk("t2_writes", writes_cnt - w0, 1);

      // Fill the FIFO, then one tenure for all four
      bif.BUSGNT = 1'b0;
      for (int k = 0; k < 4; k++) push(5'(k), t3c[k]);
      chk("t3_full_ready", 32'(bif.REQ_READY), 0);
      chk("t3_busy", 32'(bif.BUSY), 1);
      w0 = writes_cnt; d0 = done_cnt; f0 = busrq_fall;
      bif.BUSGNT = 1'b1;
      wait_done("t3_done", 200);
      chk("t3_writes", writes_cnt - w0, 4);
      chk("t3_done_cnt", done_cnt - d0, 1);
      chk("t3_busrq_falls", busrq_fall - f0, 1);
      chk("t3_drained", exp_q.size(), 0);

      // Clear sweep; a second CLEAR_START and host requests must be ignored
      w0 = writes_cnt; d0 = done_cnt;
      @(negedge CLK10);
      bif.CLEAR_COLOR = 9'h155;
      bif.CLEAR_START = 1'b1;
      for (int k = 0; k < 32; k++) exp_q.push_back({5'(k), 9'h155});
      @(negedge CLK10);
      n = 0; rdy_hi = 0;
      while (!bif.DONE && n < 400) begin
         if (bif.REQ_READY) rdy_hi++;
         bif.CLEAR_START = (n == 7);
         bif.CLEAR_COLOR = (n == 7) ? 9'h0AA : 9'h155;
         bif.REQ_VALID = (n < 20);
         bif.REQ_INDEX = 5'(n);
         @(negedge CLK10);
         n++;
      end
      bif.REQ_VALID = 1'b0;
      bif.CLEAR_START = 1'b0;
      chk("t4_done_seen", 32'(n < 400), 1);
      chk("t4_ready_low", rdy_hi, 0);
      chk("t4_done_ba", 32'(bif.BA), 0);
      repeat (40) @(negedge CLK10);
      chk("t4_writes", writes_cnt - w0, 32);
      chk("t4_done_cnt", done_cnt - d0, 1);
      chk("t4_drained", exp_q.size(), 0);

      // Grant lost in SETUP: abort, keep entry
      bif.BUSGNT = 1'b0;
      r = $urandom;
      w0 = writes_cnt;
      push(r[4:0], r[13:5]);
      n = 0;
      while (!bif.BUSRQ && n < 50) begin @(negedge CLK10); n++; end
      bif.BUSGNT = 1'b1;
      while (!bif.BUS_OE && n < 50) begin @(negedge CLK10); n++; end
      chk("t5_setup_reached", 32'(n < 50), 1);
      chk("t5_setup_cramn", 32'(bif.CRAMn), 1);
      bif.BUSGNT = 1'b0;
      repeat (6) @(negedge CLK10);
      chk("t5_no_write", writes_cnt - w0, 0);
      chk("t5_oe_off", 32'(bif.BUS_OE), 0);
      chk("t5_busrq_held", 32'(bif.BUSRQ), 1);
      bif.BUSGNT = 1'b1;
      wait_done("t5_done", 100);
      chk("t5_writes", writes_cnt - w0, 1);

      // Grant lost mid-strobe: strobe completes, second entry waits for regrant
      bif.BUSGNT = 1'b0;
      r = $urandom;
      push(r[4:0], r[13:5]);
      push(r[20:16], r[29:21]);
      w0 = writes_cnt;
      bif.BUSGNT = 1'b1;
      n = 0;
      while (bif.CRAMn && n < 50) begin @(negedge CLK10); n++; end
      chk("t5b_strobe_seen", 32'(n < 50), 1);
      bif.BUSGNT = 1'b0;
      repeat (6) @(negedge CLK10);
      chk("t5b_one_write", writes_cnt - w0, 1);
      chk("t5b_oe_off", 32'(bif.BUS_OE), 0);
      bif.BUSGNT = 1'b1;
      wait_done("t5b_done", 100);
      chk("t5b_writes", writes_cnt - w0, 2);

      // Random traffic with a flapping grant
      for (int k = 0; k < 60; k++) begin
         @(negedge CLK10);
         r = $urandom;
         bif.BUSGNT = (r[1:0] != 2'b00);
         if (bif.REQ_READY && r[2]) begin
            bif.REQ_VALID = 1'b1;
            bif.REQ_INDEX = r[12:8];
            bif.REQ_COLOR = r[21:13];
            exp_q.push_back({r[12:8], r[21:13]});
         end else begin
            bif.REQ_VALID = 1'b0;
         end
      end
      @(negedge CLK10);
      bif.REQ_VALID = 1'b0;
      bif.BUSGNT = 1'b1;
      n = 0;
      while ((bif.BUSY || exp_q.size() != 0) && n < 500) begin @(negedge CLK10); n++; end
      chk("rand_drained", 32'(n < 500), 1);

      // Reset during the strobe of clear entry 10
      w0 = writes_cnt;
      r = $urandom;
      @(negedge CLK10);
      bif.CLEAR_COLOR = r[8:0];
      bif.CLEAR_START = 1'b1;
      for (int k = 0; k < 32; k++) exp_q.push_back({5'(k), r[8:0]});
      @(negedge CLK10);
      bif.CLEAR_START = 1'b0;
      n = 0;
      while (!((writes_cnt - w0) == 10 && !bif.CRAMn && !CLK5n) && n < 300) begin
         @(negedge CLK10);
         n++;
      end
      chk("t7_entry10_strobe", 32'(n < 300), 1);
      RESET = 1'b1;
      @(negedge CLK10);
      chk("t7_cramn", 32'(bif.CRAMn), 1);
      chk("t7_busrq", 32'(bif.BUSRQ), 0);
      chk("t7_busy", 32'(bif.BUSY), 0);
      chk("t7_ready", 32'(bif.REQ_READY), 1);
      chk("t7_oe", 32'(bif.BUS_OE), 0);
      exp_q.delete();
      @(negedge CLK10);
      RESET = 1'b0;
      repeat (60) @(negedge CLK10);
      chk("t7_writes", writes_cnt - w0, 11);
      chk("t7_idle_busrq", 32'(bif.BUSRQ), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cram_palette_writer.md
Name: cram_palette_writer

Overview:
- Bus-side initiator for the color RAM write port: converts queued palette-entry writes (5-bit index, 9-bit color) into CRAMn/BD/BA write cycles.
- Timed so the RAM's write enable (~CRAMn & ~CLK5n) is asserted for exactly one CLK10 cycle per entry.
- Sits between a host/loader (save-state restore, test pattern, palette clear) and the CPU bus mux; acquires the bus through a request/grant handshake.

Parameters:
- FIFO_DEPTH, 4, number of queued write requests (power of two, 2..16).
- CLEAR_ENTRIES, 32, entries written by a clear sequence (indices 0..CLEAR_ENTRIES-1).

Ports:
- CLK10  input  1  system clock, 10 MHz.
- RESET  input  1  synchronous, active-high reset.
- CLK5n  input  1  5 MHz phase, toggles every CLK10 cycle, registered in the CLK10 domain.
- REQ_VALID  input  1  write request present.
- REQ_READY  output  1  request accepted when REQ_VALID & REQ_READY.
- REQ_INDEX  input  5  palette entry index.
- REQ_COLOR  input  9  color word, in the same bit order the color RAM stores.
- CLEAR_START  input  1  single-cycle pulse that starts a clear sequence.
- CLEAR_COLOR  input  9  value written during a clear, latched at CLEAR_START.
- BUSRQ  output  1  bus request to the CPU bus mux.
- BUSGNT  input  1  bus grant from the CPU bus mux.
- BUS_OE  output  1  high while this block drives CRAMn/BD/BA.
- CRAMn  output  1  color RAM select, active low.
- BD  output  8  data bus; carries color[7:0].
- BA  output  6  address bus; BA[5]=color[8], BA[4:0]=index.
- BUSY  output  1  state != IDLE, or FIFO not empty.
- DONE  output  1  one-cycle pulse when the last queued write or the clear sequence completes.

Behaviour:
- Reset values:
  - BUSRQ=0, BUS_OE=0, CRAMn=1, BD=0, BA=0, DONE=0, BUSY=0.
  - REQ_READY=1. FIFO empty. State IDLE.
- FIFO:
  - 14-bit entries {index, color}. REQ_READY = !full && !clearing.
  - Push and pop in the same cycle are both allowed when full, since the pop frees a slot.
  - A push while full is impossible because REQ_READY is low.
- CLEAR_START is honoured only in IDLE with an empty FIFO. Otherwise it is ignored with no side effects.
- Clear mode:
  - Generates indices 0..CLEAR_ENTRIES-1 in order, using a 5-bit counter.
  - REQ_READY is held 0 until the clear completes.
- All outputs are registered. CRAMn, BD, BA and BUS_OE change only on CLK10 edges.
- State machine:
  - IDLE: when the FIFO is non-empty or a clear is started, set BUSRQ=1 and go to WAIT_GNT.
  - WAIT_GNT: hold BUSRQ. When BUSGNT=1, set BUS_OE=1, drive BA/BD from the head entry or clear counter, keep CRAMn=1, and go to SETUP. No timeout.
  - SETUP: address/data have been stable for at least 1 cycle. When the sampled CLK5n=1, set CRAMn=0 at this edge (CLK5n goes 0 at the same edge) and go to STROBE. Otherwise wait.
    - Result: CRAMn is low for exactly 2 CLK10 cycles, and the we_n-low window is exactly the first of the two.
  - STROBE: after 2 cycles, set CRAMn=1 and pop the FIFO head (or increment the clear counter). Go to HOLD.
  - HOLD: keep BA/BD for 1 more cycle. Then:
    - if more work remains and BUSGNT=1, load the next entry and go to SETUP (back-to-back, bus retained);
    - if more work remains and BUSGNT=0, set BUS_OE=0 and go to WAIT_GNT;
    - if no work remains, set BUSRQ=0, BUS_OE=0, BA=0, BD=0, pulse DONE, and go to IDLE.
- Minimum per-entry cost is 5 CLK10 cycles (SETUP ≥1, STROBE 2, HOLD 1, plus load), i.e. 6 cycles when SETUP must wait for phase.
- Grant loss:
  - If BUSGNT drops in SETUP before the strobe, abort without writing, set BUS_OE=0, keep the entry, and go to WAIT_GNT.
  - If BUSGNT drops during STROBE or HOLD, finish the write (never truncate CRAMn), then proceed as above.
- Requests arriving during a write are queued and serviced in the same bus tenure when possible.
- When the clear counter reaches CLEAR_ENTRIES-1, that entry is the last. DONE pulses once.
- RESET mid-operation: at the next edge CRAMn=1, BUS_OE=0, BUSRQ=0, the FIFO is flushed and the clear is cancelled. A partial write is permitted to be lost.

Test Plan:
- Single write: push index=5, color=0x1A3, with BUSGNT tied 1. Required: BA=0x25, BD=0xA3, CRAMn low exactly 2 cycles, ~CRAMn&~CLK5n high exactly 1 cycle, DONE pulse, then BUSRQ=0 and BA=0.
- Grant latency: push one entry, raise BUSGNT 7 cycles after BUSRQ. Required: CRAMn stays 1 and BUS_OE=0 until grant; one write follows with the same values.
- Back-to-back: push 4 entries (idx 0..3, colors 0x000, 0x1FF, 0x0F0, 0x10F); FIFO full so REQ_READY=0. Required: 4 strobes in one tenure, BUSRQ never drops, single DONE after the 4th, writes in FIFO order.
- Clear: CLEAR_START with CLEAR_COLOR=0x155. Required: 32 writes, BA[4:0]=0..31, BA[5]=1, BD=0x55. REQ_READY=0 throughout. DONE once. CLEAR_START while busy is ignored.
- Grant drop: drop BUSGNT in SETUP. Required: no strobe, entry retained, rewritten after regrant. Drop BUSGNT mid-STROBE: strobe still 2 cycles.
- Reset mid-STROBE during clear of entry 10. Required: next cycle CRAMn=1, BUSRQ=0, BUSY=0, REQ_READY=1. No further writes.
